// File: rtl/arb_mux_n.sv
// rtl/arb_mux_n.sv - registered N-way valid/ready selector with direct, priority and round-robin grant
module arb_mux_n #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 4,
    localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [1:0]                       mode,
    input  logic [SEL_W-1:0]                 sel,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]                 out_src,
    input  logic                             out_ready
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]      out_src_q, out_src_d;
    logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [NUM_INPUTS-1:0] grant;
    logic [SEL_W-1:0]      grant_idx;
    logic                  grant_found;
    logic [DATA_WIDTH-1:0] grant_word;
    logic                  load_en;
    logic                  in_xfer;

    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        case (mode)
            2'b00: begin
                if (int'(sel) < NUM_INPUTS) begin
                    if (in_valid[sel]) begin
                        grant_found = 1'b1;
                        grant_idx   = sel;
                    end
                end
            end
            2'b10: begin
                // Walk upward from the pointer, wrapping, so the last winner goes to the back.
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    int j;
                    j = int'(rr_ptr_q) + k;
                    if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
                    if (!grant_found && in_valid[j]) begin
                        grant_found = 1'b1;
                        grant_idx   = SEL_W'(j);
                    end
                end
            end
            default: begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (!grant_found && in_valid[i]) begin
                        grant_found = 1'b1;
                        grant_idx   = SEL_W'(i);
                    end
                end
            end
        endcase
    end

    always_comb begin
        grant      = '0;
        grant_word = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_found && int'(grant_idx) == i) begin
                grant[i]   = 1'b1;
                grant_word = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_ready = rst_n ? (grant & {NUM_INPUTS{load_en}}) : '0;
    assign in_xfer  = grant_found && load_en;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_word;
            out_src_d   = grant_idx;
            if (mode == 2'b10) begin
                rr_ptr_d = (int'(grant_idx) == NUM_INPUTS - 1) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// tb/tb_arb_mux_n.sv - directed self-checking bench for arb_mux_n
module tb_arb_mux_n;

    localparam int W = 32;
    localparam int N = 4;
    localparam int SW = 2;

    logic           clk;
    logic           rst_n;
    logic [1:0]     mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_ready;

    int n_vec = 0;
    int n_bad = 0;

    arb_mux_n #(.DATA_WIDTH(W), .NUM_INPUTS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int ch, input logic [W-1:0] v);
        in_data[ch*W +: W] = v;
    endtask

    initial begin
        logic [N-1:0] exp_rdy;
        int           exp_src;
        int           seq2 [4];

        rst_n     = 1'b0;
        mode      = 2'b01;
        sel       = '0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = '0;
        set_word(0, 32'h5A);
        set_word(1, 32'h11);
        set_word(2, 32'h22);
        set_word(3, 32'h33);

        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);

        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'b0001);
        tick();
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_data", 64'(out_data), 64'h5A);
        check("post_rst_src", 64'(out_src), 64'd0);

        mode = 2'b00;
        sel  = 2'd2;
        #1;
        check("dir_in_ready", 64'(in_ready), 64'b0100);
        tick();
        check("dir_data", 64'(out_data), 64'h22);
        check("dir_src", 64'(out_src), 64'd2);
        in_valid = 4'b1011;
        #1;
        check("dir_novalid_ready", 64'(in_ready), 64'd0);
        tick();
        check("dir_drain_valid", 64'(out_valid), 64'd0);

        mode     = 2'b01;
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("pri_in_ready", 64'(in_ready), 64'b0010);
            tick();
            check("pri_src", 64'(out_src), 64'd1);
            check("pri_data", 64'(out_data), 64'h11);
        end

        mode     = 2'b10;
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            #1;
            check("rr4_in_ready", 64'(in_ready), 64'(exp_rdy));
            tick();
            check("rr4_src", 64'(out_src), 64'(k % 4));
        end
        in_valid = 4'b1001;
        seq2 = '{0, 3, 0, 3};
        for (int k = 0; k < 4; k++) begin
            exp_src = seq2[k];
            tick();
            check("rr2_src", 64'(out_src), 64'(exp_src));
        end

        mode      = 2'b01;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", 64'(out_data), 64'h33);
            check("bp_src", 64'(out_src), 64'd3);
        end
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'b0010);
        tick();
        check("bp_nobubble_valid", 64'(out_valid), 64'd1);
        check("bp_nobubble_src", 64'(out_src), 64'd1);
        check("bp_nobubble_data", 64'(out_data), 64'h11);

        set_word(2, 32'hDEADBEEF);
        mode     = 2'b10;
        in_valid = 4'b0100;
        tick();
        check("stall_load_data", 64'(out_data), 64'hDEADBEEF);
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        tick();
        check("stall_hold_data", 64'(out_data), 64'hDEADBEEF);
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", 64'(out_data), 64'd0);
        #1;
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("rr_after_rst_ready", 64'(in_ready), 64'b0001);
        tick();
        check("rr_after_rst_src", 64'(out_src), 64'd0);
        check("rr_after_rst_data", 64'(out_data), 64'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
